ip_tx_arbiter: RTL and testbench

//  Shares the single IP transmit path (header + 128-bit payload stream) between N_REQ

---
 rtl/ip_eth_pkg.sv | 38 +++
 rtl/ip_tx_arbiter_rr_pick.sv | 35 +++
 rtl/ip_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_ip_tx_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_eth_pkg.sv
// ---------------------------------------------------------------------------
// ip_eth_pkg
// Shared definitions for the IP transmit path.
//  - IPINFO_W and the bit offsets of each field in the packed IP info word
//    {Dscp6, Ecn2, Length16, TTL8, Protocol8, SrcIp32, DstIp32}
//  - ip_info_t, a struct view of the same packing
//  - encodings of the TX arbiter FSM states
// No ports (package).
// ---------------------------------------------------------------------------
package ip_eth_pkg;

  localparam int IPINFO_W = 104;

  // LSB position of each field inside the 104-bit info word
  localparam int IP_DST_LSB   = 0;
  localparam int IP_SRC_LSB   = 32;
  localparam int IP_PROTO_LSB = 64;
  localparam int IP_TTL_LSB   = 72;
  localparam int IP_LEN_LSB   = 80;
  localparam int IP_ECN_LSB   = 96;
  localparam int IP_DSCP_LSB  = 98;

  typedef struct packed {
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] length;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [31:0] srcIp;
    logic [31:0] dstIp;
  } ip_info_t;

  // Arbiter FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/ip_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// ip_tx_rr_pick
// Combinational round-robin selector: returns the index of the first set bit
// of req_i at or after ptr_i, wrapping around N_REQ.
// Ports:
//  req_i    in  N_REQ   request vector
//  ptr_i    in  PTR_W   round-robin starting position (< N_REQ)
//  grant_o  out PTR_W   selected index (0 when nothing is requested)
//  any_o    out 1       at least one request set
// ---------------------------------------------------------------------------
module ip_tx_rr_pick #(
  parameter int N_REQ = 2,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] grant_o,
  output logic             any_o
);

  // Scan from the farthest offset back towards the pointer so that the
  // closest requester at or after the pointer is the last (winning) write.
  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    any_o   = |req_i;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_i[idx]) grant_o = PTR_W'(idx);
    end
  end

endmodule

// File: rtl/ip_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ip_tx_arbiter
// Shares one IP transmit path (header + payload stream) between N_REQ
// protocol sources with packet-granular round-robin arbitration. A grant is
// taken in IDLE, held through the header handshake and released on the
// payload beat carrying last=1.
//
// Optional feature macro: IP_TX_ARB_STATS_EN
//   defined   -> adds bPkt_cnt, one 32-bit completed-packet counter per source
//   undefined -> port and counters absent, arbitration unchanged
//
// Ports:
//  wClk, wRst                 clock, async active-high reset
//  wReq_Hdr_valid/ready       per-source header handshake
//  bReq_Hdr_IPInfo            per-source packed IP info (IPINFO_W each)
//  wReq_Data_valid/ready      per-source payload handshake
//  bReq_Data_data/keep/last   per-source payload beat
//  wData_Hdr_out_valid/ready  muxed header handshake to downstream
//  bData_Hdr_out_IPInfo       muxed header fields
//  wData_out_valid/ready      muxed payload handshake to downstream
//  bData_out_data/keep/last   muxed payload beat
//  bGrant                     current / last granted source index
//  bPkt_cnt                   (IP_TX_ARB_STATS_EN only) packet counters
// ---------------------------------------------------------------------------
module ip_tx_arbiter
  import ip_eth_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 128,
  localparam int KEEP_W = DATA_W / 8,
  localparam int PTR_W  = $clog2(N_REQ)
) (
  input  logic                      wClk,
  input  logic                      wRst,
  input  logic [N_REQ-1:0]          wReq_Hdr_valid,
  output logic [N_REQ-1:0]          wReq_Hdr_ready,
  input  logic [N_REQ*IPINFO_W-1:0] bReq_Hdr_IPInfo,
  input  logic [N_REQ-1:0]          wReq_Data_valid,
  output logic [N_REQ-1:0]          wReq_Data_ready,
  input  logic [N_REQ*DATA_W-1:0]   bReq_Data_data,
  input  logic [N_REQ*KEEP_W-1:0]   bReq_Data_keep,
  input  logic [N_REQ-1:0]          wReq_Data_last,
  output logic                      wData_Hdr_out_valid,
  input  logic                      wData_Hdr_out_ready,
  output logic [IPINFO_W-1:0]       bData_Hdr_out_IPInfo,
  output logic                      wData_out_valid,
  input  logic                      wData_out_ready,
  output logic [DATA_W-1:0]         bData_out_data,
  output logic [KEEP_W-1:0]         bData_out_keep,
  output logic                      wData_out_last,
  output logic [PTR_W-1:0]          bGrant
`ifdef IP_TX_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]       bPkt_cnt
`endif
);

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [PTR_W-1:0] pickIdx;
  logic             pickAny;
  logic [N_REQ-1:0] grantOneHot;
  logic             inHdr;
  logic             inData;
  logic             hdrHs;
  logic             lastHs;

  ip_tx_rr_pick #(.N_REQ(N_REQ)) uPick (
    .req_i   (wReq_Hdr_valid),
    .ptr_i   (ptr_q),
    .grant_o (pickIdx),
    .any_o   (pickAny)
  );

  assign inHdr       = (state_q == ST_HDR);
  assign inData      = (state_q == ST_DATA);
  assign grantOneHot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

  // The muxes are driven straight from the grant register. Outputs are
  // forced to zero outside their own phase, so IDLE (and therefore reset)
  // presents all-zero valids, readies and data, and payload offered while the
  // header is still pending sees ready=0.
  assign wData_Hdr_out_valid  = inHdr & wReq_Hdr_valid[grant_q];
  assign bData_Hdr_out_IPInfo = inHdr ? bReq_Hdr_IPInfo[int'(grant_q)*IPINFO_W +: IPINFO_W] : '0;
  assign wReq_Hdr_ready       = (inHdr & wData_Hdr_out_ready) ? grantOneHot : '0;

  assign wData_out_valid = inData & wReq_Data_valid[grant_q];
  assign bData_out_data  = inData ? bReq_Data_data[int'(grant_q)*DATA_W +: DATA_W] : '0;
  assign bData_out_keep  = inData ? bReq_Data_keep[int'(grant_q)*KEEP_W +: KEEP_W] : '0;
  assign wData_out_last  = inData & wReq_Data_last[grant_q];
  assign wReq_Data_ready = (inData & wData_out_ready) ? grantOneHot : '0;

  assign hdrHs  = wData_Hdr_out_valid & wData_Hdr_out_ready;
  assign lastHs = wData_out_valid & wData_out_ready & wData_out_last;

  assign bGrant = grant_q;

  // IDLE -> HDR -> DATA -> IDLE. The grant is registered in IDLE, giving one
  // cycle of arbitration latency; the pointer only moves past the winner once
  // its packet has fully completed, so requests arriving mid-packet just wait.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pickAny) begin
          grant_d = pickIdx;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (hdrHs) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (lastHs) begin
          state_d = ST_IDLE;
          ptr_d   = (grant_q == PTR_W'(N_REQ - 1)) ? '0 : grant_q + PTR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wClk or posedge wRst) begin
    if (wRst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef IP_TX_ARB_STATS_EN
  // One free-running wrap-around counter per source, bumped on the
  // last-beat handshake of a packet owned by that source.
  for (genvar i = 0; i < N_REQ; i++) begin : gPktCnt
    logic [31:0] pktCnt_q;

    always_ff @(posedge wClk or posedge wRst) begin
      if (wRst) begin
        pktCnt_q <= '0;
      end else if (lastHs && (grant_q == PTR_W'(i))) begin
        pktCnt_q <= pktCnt_q + 32'd1;
      end
    end

    assign bPkt_cnt[i*32 +: 32] = pktCnt_q;
  end
`endif

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ip_tx_arbiter
// Randomised stimulus for ip_tx_arbiter (N_REQ=4). Each source generates
// packets whose header and beats are pushed into scoreboard queues when the
// packet is created; an independent monitor predicts the winner of every
// arbitration from the round-robin rule and pops/compares whatever the DUT
// emits. Inputs change at the falling edge, outputs are sampled 2ns later.
// ---------------------------------------------------------------------------
module tb_ip_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int KW = DW / 8;
  localparam int IW = 104;
  localparam int PW = 2;

  logic          wClk;
  logic          wRst;
  logic [N-1:0]    wReq_Hdr_valid;
  logic [N-1:0]    wReq_Hdr_ready;
  logic [N*IW-1:0] bReq_Hdr_IPInfo;
  logic [N-1:0]    wReq_Data_valid;
  logic [N-1:0]    wReq_Data_ready;
  logic [N*DW-1:0] bReq_Data_data;
  logic [N*KW-1:0] bReq_Data_keep;
  logic [N-1:0]    wReq_Data_last;
  logic            wData_Hdr_out_valid;
  logic            wData_Hdr_out_ready;
  logic [IW-1:0]   bData_Hdr_out_IPInfo;
  logic            wData_out_valid;
  logic            wData_out_ready;
  logic [DW-1:0]   bData_out_data;
  logic [KW-1:0]   bData_out_keep;
  logic            wData_out_last;
  logic [PW-1:0]   bGrant;
`ifdef IP_TX_ARB_STATS_EN
  logic [N*32-1:0] bPkt_cnt;
`endif

  ip_tx_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .wClk                 (wClk),
    .wRst                 (wRst),
    .wReq_Hdr_valid       (wReq_Hdr_valid),
    .wReq_Hdr_ready       (wReq_Hdr_ready),
    .bReq_Hdr_IPInfo      (bReq_Hdr_IPInfo),
    .wReq_Data_valid      (wReq_Data_valid),
    .wReq_Data_ready      (wReq_Data_ready),
    .bReq_Data_data       (bReq_Data_data),
    .bReq_Data_keep       (bReq_Data_keep),
    .wReq_Data_last       (wReq_Data_last),
    .wData_Hdr_out_valid  (wData_Hdr_out_valid),
    .wData_Hdr_out_ready  (wData_Hdr_out_ready),
    .bData_Hdr_out_IPInfo (bData_Hdr_out_IPInfo),
    .wData_out_valid      (wData_out_valid),
    .wData_out_ready      (wData_out_ready),
    .bData_out_data       (bData_out_data),
    .bData_out_keep       (bData_out_keep),
    .wData_out_last       (wData_out_last),
    .bGrant               (bGrant)
`ifdef IP_TX_ARB_STATS_EN
    ,
    .bPkt_cnt             (bPkt_cnt)
`endif
  );

  initial begin
    wClk = 1'b0;
    forever #5 wClk = ~wClk;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            id;
    logic [IW-1:0] info;
  } hdrExp_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beatExp_t;

  hdrExp_t  hdrQ[$];
  beatExp_t beatQ[$];

  // Per-source stimulus state: phase 0 = idle/gap, 1 = header offered,
  // 2 = streaming payload.
  int            phase[N];
  int            gap[N];
  int            beat[N];
  int            nBeats[N];
  int            pktsLeft[N];
  logic [IW-1:0] curInfo[N];
  logic [DW-1:0] curData[N][8];
  logic [KW-1:0] curKeep[N][8];
  bit            tookHdr[N];
  bit            tookData[N];
  bit            dValidPrev[N];

  int cfgGapMax, cfgBeatMin, cfgBeatMax, cfgReadyMode, cfgValidPct;
  int cfgResetReq, cfgResetBeat;
  bit rstDone;

  // Reference model state kept by the monitor
  int           ptrModel;
  int           curGrant;
  int           cntModel[N];
  bit           hdrPrev;
  bit           hStallPrev;
  bit           dStallPrev;
  logic [N-1:0] reqPrev;
  logic [159:0] prevHdr;
  logic [159:0] prevBeat;

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: expected entry not found", name);
  endtask

  // Round-robin rule: first requesting source at or after the pointer.
  function automatic int rrModel(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic startPacket(input int r);
    logic [127:0] rnd;
    nBeats[r] = $urandom_range(cfgBeatMax, cfgBeatMin);
    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    curInfo[r] = rnd[IW-1:0];
    hdrQ.push_back('{id: r, info: curInfo[r]});
    for (int b = 0; b < nBeats[r]; b++) begin
      curData[r][b] = {$urandom(), $urandom(), $urandom(), $urandom()};
      curKeep[r][b] = (b == nBeats[r] - 1) ? KW'($urandom_range(16'hFFFF, 1)) : '1;
      beatQ.push_back('{id: r, data: curData[r][b], keep: curKeep[r][b], last: (b == nBeats[r] - 1)});
    end
    beat[r]       = 0;
    phase[r]      = 1;
    dValidPrev[r] = 1'b0;
  endtask

  // One stimulus cycle: retire last cycle's handshakes, launch new packets,
  // drive every source, then note which handshakes the coming edge takes.
  task automatic applyStimulus();
    @(negedge wClk);
    if (wRst) begin
      wRst = 1'b0;
      for (int r = 0; r < N; r++) begin
        phase[r]      = 0;
        pktsLeft[r]   = 0;
        gap[r]        = 0;
        dValidPrev[r] = 1'b0;
      end
    end else begin
      for (int r = 0; r < N; r++) begin
        if (tookHdr[r]) begin
          phase[r] = 2;
          beat[r]  = 0;
        end else if (tookData[r] && phase[r] == 2) begin
          beat[r]++;
          if (beat[r] == nBeats[r]) begin
            phase[r] = 0;
            pktsLeft[r]--;
            gap[r] = $urandom_range(cfgGapMax, 0);
          end
        end
      end
    end

    for (int r = 0; r < N; r++) begin
      if (phase[r] == 0 && pktsLeft[r] > 0) begin
        if (gap[r] > 0) gap[r]--;
        else startPacket(r);
      end
    end

    for (int r = 0; r < N; r++) begin
      case (phase[r])
        1: begin
          wReq_Hdr_valid[r]  = 1'b1;
          wReq_Data_valid[r] = 1'b1;
        end
        2: begin
          wReq_Hdr_valid[r]  = 1'b0;
          if (dValidPrev[r] && !tookData[r]) wReq_Data_valid[r] = 1'b1;
          else wReq_Data_valid[r] = ($urandom_range(100, 1) <= cfgValidPct);
        end
        default: begin
          wReq_Hdr_valid[r]  = 1'b0;
          wReq_Data_valid[r] = 1'b0;
        end
      endcase
      if (phase[r] != 0) begin
        bReq_Hdr_IPInfo[r*IW +: IW] = curInfo[r];
        bReq_Data_data[r*DW +: DW]  = curData[r][beat[r]];
        bReq_Data_keep[r*KW +: KW]  = curKeep[r][beat[r]];
        wReq_Data_last[r]           = (beat[r] == nBeats[r] - 1);
      end
    end

    case (cfgReadyMode)
      0: begin
        wData_out_ready     = 1'b1;
        wData_Hdr_out_ready = 1'b1;
      end
      1: begin
        wData_out_ready     = ~wData_out_ready;
        wData_Hdr_out_ready = 1'($urandom_range(1, 0));
      end
      default: begin
        wData_out_ready     = 1'($urandom_range(1, 0));
        wData_Hdr_out_ready = 1'($urandom_range(1, 0));
      end
    endcase

    if (cfgResetBeat >= 0 && !rstDone && phase[cfgResetReq] == 2 && beat[cfgResetReq] == cfgResetBeat) begin
      wRst    = 1'b1;
      rstDone = 1'b1;
    end

    #1;
    for (int r = 0; r < N; r++) begin
      tookHdr[r]    = !wRst && wReq_Hdr_valid[r] && wReq_Hdr_ready[r];
      tookData[r]   = !wRst && wReq_Data_valid[r] && wReq_Data_ready[r];
      dValidPrev[r] = wReq_Data_valid[r];
    end
  endtask

  task automatic setCfg(input logic [N-1:0] mask, input int pkts, input int gapMax,
                        input int bMin, input int bMax, input int readyMode,
                        input int validPct, input int resetReq, input int resetBeat);
    cfgGapMax    = gapMax;
    cfgBeatMin   = bMin;
    cfgBeatMax   = bMax;
    cfgReadyMode = readyMode;
    cfgValidPct  = validPct;
    cfgResetReq  = resetReq;
    cfgResetBeat = resetBeat;
    rstDone      = 1'b0;
    for (int r = 0; r < N; r++) begin
      pktsLeft[r] = mask[r] ? pkts : 0;
      gap[r]      = 0;
    end
  endtask

  task automatic runPhase(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      applyStimulus();
      done = (hdrQ.size() == 0) && (beatQ.size() == 0);
      for (int r = 0; r < N; r++) begin
        if (pktsLeft[r] != 0 || phase[r] != 0) done = 1'b0;
      end
    end
    checkOutput({name, "_done"}, 160'(done), 160'(1));
    repeat (2) @(negedge wClk);
`ifdef IP_TX_ARB_STATS_EN
    for (int r = 0; r < N; r++) begin
      checkOutput($sformatf("%s_pkt_cnt%0d", name, r), 160'(bPkt_cnt[r*32 +: 32]), 160'(cntModel[r]));
    end
`endif
  endtask

  // Monitor: predicts grants, pops the scoreboard on every output handshake
  // and checks the invariants that hold every cycle.
  initial begin
    logic [N-1:0] mask;
    int           expG;
    int           idx;
    ptrModel   = 0;
    curGrant   = 0;
    hdrPrev    = 1'b0;
    hStallPrev = 1'b0;
    dStallPrev = 1'b0;
    reqPrev    = '0;
    for (int r = 0; r < N; r++) cntModel[r] = 0;
    forever begin
      @(negedge wClk);
      #2;
      if (wRst) begin
        checkOutput("reset_ctrl", 160'({wData_Hdr_out_valid, wData_out_valid, wData_out_last,
                    wReq_Hdr_ready, wReq_Data_ready, bGrant}), 160'(0));
        checkOutput("reset_data", 160'({bData_out_data, bData_out_keep}), 160'(0));
        checkOutput("reset_hdr", 160'(bData_Hdr_out_IPInfo), 160'(0));
        ptrModel   = 0;
        hdrPrev    = 1'b0;
        hStallPrev = 1'b0;
        dStallPrev = 1'b0;
        hdrQ.delete();
        beatQ.delete();
        for (int r = 0; r < N; r++) cntModel[r] = 0;
      end else begin
        mask = ~(N'(1) << bGrant);
        checkOutput("nongrant_ready", 160'({wReq_Hdr_ready & mask, wReq_Data_ready & mask}), 160'(0));
        if (wData_Hdr_out_valid) checkOutput("data_before_hdr", 160'(wReq_Data_ready), 160'(0));
        if (hStallPrev) checkOutput("hdr_stall_stable", 160'({wData_Hdr_out_valid, bData_Hdr_out_IPInfo}), prevHdr);
        if (dStallPrev) checkOutput("data_stall_stable",
                                    160'({wData_out_valid, bData_out_data, bData_out_keep, wData_out_last}), prevBeat);

        if (wData_Hdr_out_valid && !hdrPrev) begin
          expG = rrModel(reqPrev, ptrModel);
          checkOutput("grant", 160'(bGrant), 160'(expG));
          curGrant = (expG >= 0) ? expG : int'(bGrant);
        end

        if (wData_Hdr_out_valid && wData_Hdr_out_ready) begin
          idx = -1;
          foreach (hdrQ[i]) if (idx < 0 && hdrQ[i].id == curGrant) idx = i;
          if (idx < 0) failNow("hdr_unexpected");
          else begin
            checkOutput("hdr_fields", 160'(bData_Hdr_out_IPInfo), 160'(hdrQ[idx].info));
            hdrQ.delete(idx);
          end
        end

        if (wData_out_valid && wData_out_ready) begin
          checkOutput("grant_hold", 160'(bGrant), 160'(curGrant));
          idx = -1;
          foreach (beatQ[i]) if (idx < 0 && beatQ[i].id == curGrant) idx = i;
          if (idx < 0) failNow("beat_unexpected");
          else begin
            checkOutput("beat", 160'({bData_out_data, bData_out_keep, wData_out_last}),
                        160'({beatQ[idx].data, beatQ[idx].keep, beatQ[idx].last}));
            beatQ.delete(idx);
          end
          if (wData_out_last) begin
            ptrModel = (curGrant + 1) % N;
            cntModel[curGrant]++;
          end
        end

        hdrPrev    = wData_Hdr_out_valid;
        hStallPrev = wData_Hdr_out_valid && !wData_Hdr_out_ready;
        dStallPrev = wData_out_valid && !wData_out_ready;
        prevHdr    = 160'({wData_Hdr_out_valid, bData_Hdr_out_IPInfo});
        prevBeat   = 160'({wData_out_valid, bData_out_data, bData_out_keep, wData_out_last});
      end
      reqPrev = wReq_Hdr_valid;
    end
  end

  initial begin
    wRst                = 1'b1;
    wReq_Hdr_valid      = '0;
    bReq_Hdr_IPInfo     = '0;
    wReq_Data_valid     = '0;
    bReq_Data_data      = '0;
    bReq_Data_keep      = '0;
    wReq_Data_last      = '0;
    wData_Hdr_out_ready = 1'b0;
    wData_out_ready     = 1'b0;
    for (int r = 0; r < N; r++) begin
      phase[r]      = 0;
      beat[r]       = 0;
      nBeats[r]     = 1;
      tookHdr[r]    = 1'b0;
      tookData[r]   = 1'b0;
      dValidPrev[r] = 1'b0;
    end
    setCfg(4'b0000, 0, 0, 1, 1, 0, 100, 0, -1);
    repeat (3) @(negedge wClk);

    // Single source 0 packet of 3 beats; leaves the pointer at 1
    setCfg(4'b0001, 1, 0, 3, 3, 0, 100, 0, -1);
    runPhase("single", 200);

    // Source 1 packet of 4 beats, reset while its second beat is presented
    setCfg(4'b0010, 1, 0, 4, 4, 0, 100, 1, 1);
    runPhase("reset", 200);

    // Sources 0 and 1 contend from a freshly reset pointer: 0,1,0,1
    setCfg(4'b0011, 2, 0, 1, 3, 0, 100, 0, -1);
    runPhase("contend", 400);

    // All sources, random gaps/lengths, downstream data ready toggling
    setCfg(4'b1111, 6, 3, 1, 5, 1, 70, 0, -1);
    runPhase("toggle", 3000);

    // All sources, fully random back-pressure
    setCfg(4'b1111, 8, 2, 1, 4, 2, 60, 0, -1);
    runPhase("random", 4000);

    // All sources continuously requesting, 2-beat packets: 0,1,2,3 repeating
    setCfg(4'b1111, 3, 0, 2, 2, 0, 100, 0, -1);
    runPhase("allreq", 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
